ifetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the decode/CU stage in the CPU datapath. It owns the program counter, issues reads to a synchronous-read instruction memory, and buffers returned instructions in a 2-entry queue. It presents each instruction, tagged with its PC, to the decode stage over a valid/ready handshake. It also handles jump redirects, which flush everything younger, and a HALT opcode, which stops fetching.

---
 rtl/ifetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction memory and
// hands {pc, ins} pairs to decode through a 2-entry queue with valid/ready.
module ifetch_stage #(
    parameter int              PC_W     = 7,
    parameter int              INS_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      HALT_OPC = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_rd_en,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_data,
    input  logic             redirect_en,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [INS_W-1:0] ins,
    output logic [PC_W-1:0]  ins_pc,
    output logic             halted
);

    logic [PC_W-1:0]  fetchPc_q, fetchPc_d;
    logic [PC_W-1:0]  inflightPc_q, inflightPc_d;
    logic             inflight_q, inflight_d;
    logic             halted_q, halted_d;
    logic [1:0]       count_q, count_d;
    logic [PC_W-1:0]  entryPc_q [2];
    logic [PC_W-1:0]  entryPc_d [2];
    logic [INS_W-1:0] entryIns_q [2];
    logic [INS_W-1:0] entryIns_d [2];

    logic       pop;
    logic       push;
    logic       haltArriving;
    logic       issue;
    logic [2:0] credit;
    logic [1:0] pushSlot;

    // Credit counts queued plus in-flight words after this cycle's pop, so a
    // response always has a free slot when it lands.
    always_comb begin
        pop          = (count_q != 2'd0) && ins_ready;
        push         = inflight_q && !redirect_en;
        haltArriving = inflight_q && (imem_data[INS_W-1 -: 7] == HALT_OPC) && !redirect_en;
        credit       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue        = !rst && !halted_q && !redirect_en && !haltArriving && (credit < 3'd2);
        pushSlot     = count_q - {1'b0, pop};

        fetchPc_d    = fetchPc_q;
        inflightPc_d = inflightPc_q;
        inflight_d   = issue;
        halted_d     = halted_q | haltArriving;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        entryPc_d    = entryPc_q;
        entryIns_d   = entryIns_q;

        if (issue) begin
            fetchPc_d    = fetchPc_q + PC_W'(1);
            inflightPc_d = fetchPc_q;
        end

        if (pop) begin
            entryPc_d[0]  = entryPc_q[1];
            entryIns_d[0] = entryIns_q[1];
        end

        if (push) begin
            if (pushSlot == 2'd0) begin
                entryPc_d[0]  = inflightPc_q;
                entryIns_d[0] = imem_data;
            end else begin
                entryPc_d[1]  = inflightPc_q;
                entryIns_d[1] = imem_data;
            end
        end

        // Redirect flushes the queue and kills any response landing this cycle.
        if (redirect_en) begin
            count_d   = 2'd0;
            fetchPc_d = redirect_pc;
            halted_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            inflightPc_q  <= '0;
            inflight_q    <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= 2'd0;
            entryPc_q[0]  <= '0;
            entryPc_q[1]  <= '0;
            entryIns_q[0] <= '0;
            entryIns_q[1] <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            inflightPc_q  <= inflightPc_d;
            inflight_q    <= inflight_d;
            halted_q      <= halted_d;
            count_q       <= count_d;
            entryPc_q     <= entryPc_d;
            entryIns_q    <= entryIns_d;
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = fetchPc_q;
    assign ins_valid  = (count_q != 2'd0);
    assign ins        = ins_valid ? entryIns_q[0] : '0;
    assign ins_pc     = ins_valid ? entryPc_q[0] : '0;
    assign halted     = halted_q;

endmodule
